lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/rv_pkg.sv | 16 +
 rtl/lsu_align.sv | 66 ++++++
 rtl/lsu.sv | 116 +++++++++++
 tb/tb_lsu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the load/store unit: FSM states and funct3 width codes.
package rv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte enables and store replication for the
// incoming op, plus lane select and sign/zero extension for the returning load data.
module lsu_align
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic            bad,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_lane,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        bad       = 1'b0;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << lane;
                wdata_rep = {(XLEN/8){wdata[7:0]}};
            end
            F3_H: begin
                be        = 4'b0011 << lane;
                wdata_rep = {(XLEN/16){wdata[15:0]}};
                bad       = lane[0];
            end
            F3_W: begin
                be  = 4'b1111;
                bad = (lane != 2'b00);
            end
            // Unsigned widths exist only for loads.
            F3_BU: begin
                be  = 4'b0001 << lane;
                bad = we;
            end
            F3_HU: begin
                be  = 4'b0011 << lane;
                bad = we | lane[0];
            end
            default: bad = 1'b1;
        endcase
    end

    logic [XLEN-1:0] shifted;
    assign shifted = rdata >> {ld_lane, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (ld_funct3)
            F3_B:    ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time from EXE/MEM, drives a req/gnt data
// memory port and returns extended load results to MEM/WB.
module lsu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            dmem_req,
    input  logic            dmem_gnt,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            stall,
    output logic            misalign
);

    lsu_state_t      state;
    logic [2:0]      op_funct3;
    logic [1:0]      op_lane;
    logic [4:0]      op_rd;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] ld_data;
    logic            req_bad;

    lsu_align #(.XLEN(XLEN)) u_align (
        .we        (req_we),
        .funct3    (req_funct3),
        .lane      (req_addr[1:0]),
        .wdata     (req_wdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .bad       (req_bad),
        .ld_funct3 (op_funct3),
        .ld_lane   (op_lane),
        .rdata     (dmem_rdata),
        .ld_data   (ld_data)
    );

    assign req_ready = (state == ST_IDLE);
    assign stall     = rst_n & ((state == ST_IDLE) ? (req_valid & ~req_bad) : 1'b1);

    // rsp_valid and misalign are single-cycle pulses; everything on dmem_* is latched at
    // acceptance so it stays stable for however long the memory withholds the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_funct3  <= 3'b000;
            op_lane    <= 2'b00;
            op_rd      <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'b0000;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_rd     <= 5'd0;
            misalign   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            misalign <= 1'b1;
                        end else begin
                            state      <= ST_REQ;
                            op_funct3  <= req_funct3;
                            op_lane    <= req_addr[1:0];
                            op_rd      <= req_rd;
                            dmem_req   <= 1'b1;
                            dmem_we    <= req_we;
                            dmem_be    <= be;
                            dmem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            dmem_wdata <= wdata_rep;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= dmem_we ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= ld_data;
                        rsp_rd    <= op_rd;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads with lane extension, stores with lane
// replication, misaligned rejection, grant back-pressure and reset during WAIT.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dmem_req;
    logic        dmem_gnt;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        stall;
    logic        misalign;

    int checks;
    int failures;

    lsu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .dmem_req    (dmem_req),
        .dmem_gnt    (dmem_gnt),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_rd      (rsp_rd),
        .stall       (stall),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Presents one op; caller is at posedge+1 and the op is accepted on the next edge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
    endtask

    // Load with grant on the first REQ cycle; a bogus rvalid rides along with the grant
    // and must be ignored, the real data arrives one cycle later.
    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
        applyStimulus(1'b0, f3, addr, 32'h0, rd);
        @(negedge clk);
        checkOutput({tag, ".stall_idle"}, {31'd0, stall}, 32'd1);
        checkOutput({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".dmem_req"}, {31'd0, dmem_req}, 32'd1);
        checkOutput({tag, ".dmem_we"}, {31'd0, dmem_we}, 32'd0);
        checkOutput({tag, ".dmem_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        checkOutput({tag, ".dmem_addr"}, dmem_addr, {addr[31:2], 2'b00});
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = ~rdata;
        @(posedge clk); #1;
        dmem_gnt   = 1'b0;
        dmem_rdata = rdata;
        @(negedge clk);
        checkOutput({tag, ".req_after_gnt"}, {31'd0, dmem_req}, 32'd0);
        checkOutput({tag, ".no_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, ".stall_wait"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        checkOutput({tag, ".rsp_data"}, rsp_data, exp_data);
        checkOutput({tag, ".rsp_rd"}, {27'd0, rsp_rd}, {27'd0, rd});
        checkOutput({tag, ".ready_done"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, ".rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    // Store with the grant withheld for gnt_delay cycles; returns at posedge+1 right after
    // the grant edge so the caller can issue the next op back-to-back.
    task automatic doStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gnt_delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        applyStimulus(1'b1, f3, addr, wdata, 5'd0);
        @(negedge clk);
        checkOutput({tag, ".stall_idle"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            checkOutput({tag, ".hold_req"}, {31'd0, dmem_req}, 32'd1);
            checkOutput({tag, ".hold_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
            checkOutput({tag, ".hold_wdata"}, dmem_wdata, exp_wdata);
            checkOutput({tag, ".hold_addr"}, dmem_addr, {addr[31:2], 2'b00});
            checkOutput({tag, ".hold_stall"}, {31'd0, stall}, 32'd1);
            checkOutput({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput({tag, ".dmem_req"}, {31'd0, dmem_req}, 32'd1);
        checkOutput({tag, ".dmem_we"}, {31'd0, dmem_we}, 32'd1);
        checkOutput({tag, ".dmem_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        checkOutput({tag, ".dmem_wdata"}, dmem_wdata, exp_wdata);
        checkOutput({tag, ".dmem_addr"}, dmem_addr, {addr[31:2], 2'b00});
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        checkOutput({tag, ".req_after_gnt"}, {31'd0, dmem_req}, 32'd0);
        checkOutput({tag, ".ready_done"}, {31'd0, req_ready}, 32'd1);
        checkOutput({tag, ".no_rsp"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic doMisalign(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr);
        applyStimulus(we, f3, addr, 32'h1234_5678, 5'd3);
        @(negedge clk);
        checkOutput({tag, ".stall"}, {31'd0, stall}, 32'd0);
        checkOutput({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".misalign"}, {31'd0, misalign}, 32'd1);
        checkOutput({tag, ".no_req"}, {31'd0, dmem_req}, 32'd0);
        checkOutput({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, ".misalign_pulse"}, {31'd0, misalign}, 32'd0);
        checkOutput({tag, ".still_no_req"}, {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_rd      = 5'd0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;

        // Reset values, with an aligned op presented so stall must still be held low.
        #2;
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
        #10;
        checkOutput("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("rst.dmem_we", {31'd0, dmem_we}, 32'd0);
        checkOutput("rst.dmem_be", {28'd0, dmem_be}, 32'd0);
        checkOutput("rst.dmem_addr", dmem_addr, 32'd0);
        checkOutput("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst.rsp_rd", {27'd0, rsp_rd}, 32'd0);
        checkOutput("rst.misalign", {31'd0, misalign}, 32'd0);
        checkOutput("rst.stall", {31'd0, stall}, 32'd0);
        checkOutput("rst.ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        #8 rst_n = 1'b1;
        @(posedge clk); #1;

        doLoad("lw",  3'b010, 32'h0000_0100, 5'd5,  32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        doLoad("lb",  3'b000, 32'h0000_0103, 5'd7,  32'h80FF_FF7F, 4'b1000, 32'hFFFF_FF80);
        doLoad("lbu", 3'b100, 32'h0000_0103, 5'd8,  32'h80FF_FF7F, 4'b1000, 32'h0000_0080);
        doLoad("lh",  3'b001, 32'h0000_0102, 5'd9,  32'h80FF_FF7F, 4'b1100, 32'hFFFF_80FF);
        doLoad("lhu", 3'b101, 32'h0000_0102, 5'd10, 32'h80FF_FF7F, 4'b1100, 32'h0000_80FF);
        doLoad("lb0", 3'b000, 32'h0000_0100, 5'd11, 32'h80FF_FF7F, 4'b0001, 32'h0000_007F);
        doLoad("lh0", 3'b001, 32'h0000_0100, 5'd12, 32'h1234_F00D, 4'b0011, 32'hFFFF_F00D);

        doStore("sb", 3'b000, 32'h0000_0201, 32'h0000_00AB, 0, 4'b0010, 32'hABAB_ABAB);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("sb.no_rsp_later", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end

        doStore("sh_gnt3", 3'b001, 32'h0000_0102, 32'hFFFF_1234, 3, 4'b1100, 32'h1234_1234);

        // Back-to-back: the load is presented in the first cycle after the store's grant.
        doStore("sw", 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);
        doLoad("b2b_lw", 3'b010, 32'h0000_0204, 5'd31, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        doMisalign("sw_202",  1'b1, 3'b010, 32'h0000_0202);
        doMisalign("lh_101",  1'b0, 3'b001, 32'h0000_0101);
        doMisalign("lw_102",  1'b0, 3'b010, 32'h0000_0102);
        doMisalign("ld_f3_3", 1'b0, 3'b011, 32'h0000_0100);
        doMisalign("st_f3_4", 1'b1, 3'b100, 32'h0000_0100);

        // Reset while WAITing for load data, then a stale rvalid must be dropped.
        applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd9);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("rstwait.stall_wait", {31'd0, stall}, 32'd1);
        checkOutput("rstwait.ready_wait", {31'd0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstwait.ready_rst", {31'd0, req_ready}, 32'd1);
        checkOutput("rstwait.stall_rst", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("rstwait.no_rsp", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstwait.rsp_rd", {27'd0, rsp_rd}, 32'd0);
        checkOutput("rstwait.idle", {31'd0, req_ready}, 32'd1);
        checkOutput("rstwait.no_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstwait.no_rsp_later", {31'd0, rsp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
